// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame packer.
// The frame state enum, default framing bytes and the payload XOR helper live here.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_CHECKSUM,
        ST_TRAILER
    } frame_state_e;

    localparam logic [7:0] DEFAULT_HEADER    = 8'hAA;
    localparam logic [7:0] DEFAULT_TRAILER   = 8'h55;
    localparam int         MAX_PAYLOAD_BYTES = 16;

    // XOR of the low nbytes bytes of data; nbytes is clipped to MAX_PAYLOAD_BYTES.
    function automatic logic [7:0] xor_reduce_bytes(
        input logic [8*MAX_PAYLOAD_BYTES-1:0] data,
        input int                             nbytes
    );
        logic [7:0] acc;
        acc = '0;
        for (int k = 0; k < MAX_PAYLOAD_BYTES; k++) begin
            if (k < nbytes) acc ^= data[8*k +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// Frame packer: captures one payload word and streams HEADER, payload bytes, [checksum], TRAILER
// to the byte-wide UART transmitter. Checksum byte enabled by defining UART_FRAME_CHECKSUM_EN.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 2,
    parameter logic [7:0] HEADER        = DEFAULT_HEADER,
    parameter logic [7:0] TRAILER       = DEFAULT_TRAILER,
    parameter bit         MSB_FIRST     = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    input  logic                       payload_valid,
    output logic                       payload_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_data_valid,
    input  logic                       tx_data_ack,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_data_valid,
    output logic [7:0]                 rx_last,
    output logic [15:0]                frames_sent
);

    localparam int              PW       = 8 * PAYLOAD_BYTES;
    localparam int              IDX_W    = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

    frame_state_e     state;
    logic [PW-1:0]    payload_q;
    logic [IDX_W-1:0] idx;
    logic             xfer;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    // Byte k in wire order, honouring MSB_FIRST.
    function automatic logic [7:0] byte_at(input logic [PW-1:0] w, input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] sel;
        sel = MSB_FIRST ? (LAST_IDX - k) : k;
        return w[8*sel +: 8];
    endfunction

    assign payload_ready = (state == ST_IDLE);
    assign xfer          = tx_data_valid && tx_data_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            payload_q     <= '0;
            idx           <= '0;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            frames_sent   <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (payload_valid) begin
                        payload_q     <= payload;
                        idx           <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                        csum_q        <= '0;
`endif
                        tx_data       <= HEADER;
                        tx_data_valid <= 1'b1;
                        state         <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (xfer) begin
                        tx_data <= byte_at(payload_q, '0);
                        state   <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
`ifdef UART_FRAME_CHECKSUM_EN
                        csum_q <= csum_q ^ tx_data;
`endif
                        if (idx == LAST_IDX) begin
`ifdef UART_FRAME_CHECKSUM_EN
                            // Fold in the byte leaving now so the checksum is ready without a bubble.
                            tx_data <= csum_q ^ tx_data;
                            state   <= ST_CHECKSUM;
`else
                            tx_data <= TRAILER;
                            state   <= ST_TRAILER;
`endif
                        end else begin
                            idx     <= idx + 1'b1;
                            tx_data <= byte_at(payload_q, idx + 1'b1);
                        end
                    end
                end
`ifdef UART_FRAME_CHECKSUM_EN
                ST_CHECKSUM: begin
                    if (xfer) begin
                        tx_data <= TRAILER;
                        state   <= ST_TRAILER;
                    end
                end
`endif
                ST_TRAILER: begin
                    if (xfer) begin
                        tx_data       <= '0;
                        tx_data_valid <= 1'b0;
                        frames_sent   <= frames_sent + 16'd1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    tx_data_valid <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             rx_last <= '0;
        else if (rx_data_valid) rx_last <= rx_data;
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Randomized scoreboard bench for uart_frame_tx: two instances (2-byte MSB-first, 4-byte LSB-first)
// checked byte-by-byte against a frame model built from the framing rules.
module tb_uart_frame_tx;

`ifdef UART_FRAME_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] pay_a = '0;
    logic [31:0] pay_b = '0;
    logic        pv  [2] = '{1'b0, 1'b0};
    logic        pr  [2];
    logic        tv  [2];
    logic        ack [2] = '{1'b1, 1'b1};
    logic [7:0]  txd [2];
    logic [15:0] fs  [2];
    logic [7:0]  rxl [2];
    logic [7:0]  rx_data  = '0;
    logic        rx_valid = 1'b0;

    int          checks   = 0;
    int          failures = 0;
    int          mode     = 0;  // 0: ack always 1, 1: random ack, 2: ack held low
    logic [15:0] frames_exp [2] = '{16'h0, 16'h0};

    uart_frame_tx #(.PAYLOAD_BYTES(2), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .payload(pay_a), .payload_valid(pv[0]), .payload_ready(pr[0]),
        .tx_data(txd[0]), .tx_data_valid(tv[0]), .tx_data_ack(ack[0]),
        .rx_data(rx_data), .rx_data_valid(rx_valid), .rx_last(rxl[0]), .frames_sent(fs[0]));

    uart_frame_tx #(.PAYLOAD_BYTES(4), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .payload(pay_b), .payload_valid(pv[1]), .payload_ready(pr[1]),
        .tx_data(txd[1]), .tx_data_valid(tv[1]), .tx_data_ack(ack[1]),
        .rx_data(rx_data), .rx_data_valid(rx_valid), .rx_last(rxl[1]), .frames_sent(fs[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // Ack driver; changes just after the active edge so it is stable at the sampling edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++)
            ack[i] = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    end

    // Scoreboard: expected frame pushed at acceptance, popped on every byte transfer.
    logic [7:0]  exp_q [2][$];
    int          rem    [2] = '{0, 0};
    logic        held   [2] = '{1'b0, 1'b0};
    logic [7:0]  held_d [2];
    logic [31:0] mw;
    logic [7:0]  mb, mx;
    int          mnb, mpos;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                exp_q[i].delete();
                rem[i]  = 0;
                held[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                check("payload_ready", {31'd0, pr[i]}, {31'd0, rem[i] == 0});
                check("tx_data_valid", {31'd0, tv[i]}, {31'd0, rem[i] != 0});
                if (held[i]) check("tx_data_stable", {24'd0, txd[i]}, {24'd0, held_d[i]});
                if (pv[i] && pr[i]) begin
                    mw  = (i == 0) ? {16'd0, pay_a} : pay_b;
                    mnb = (i == 0) ? 2 : 4;
                    mx  = 8'h00;
                    exp_q[i].push_back(8'hAA);
                    for (int k = 0; k < mnb; k++) begin
                        mpos = (i == 0) ? (mnb - 1 - k) : k;
                        mb   = 8'((mw >> (8 * mpos)) & 32'hFF);
                        mx   = mx ^ mb;
                        exp_q[i].push_back(mb);
                    end
                    if (CS == 1) exp_q[i].push_back(mx);
                    exp_q[i].push_back(8'h55);
                    rem[i] = mnb + 2 + CS;
                end else if (tv[i] && ack[i]) begin
                    if (exp_q[i].size() == 0) fail_now("extra_tx_byte");
                    else begin
                        check("tx_byte", {24'd0, txd[i]}, {24'd0, exp_q[i].pop_front()});
                        if (rem[i] > 0) rem[i]--;
                    end
                end
                held[i]   = tv[i] && !ack[i];
                held_d[i] = txd[i];
            end
        end
    end

    task automatic offer(input int i, input logic [31:0] w);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        if (i == 0) pay_a = w[15:0];
        else        pay_b = w;
        pv[i] = 1'b1;
        forever begin
            @(negedge clk);
            if (pr[i]) break;
            n++;
            if (n > 500) begin
                fail_now("accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        pv[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (pr[i]) break;
            n++;
            if (n > 500) begin
                fail_now("frame_timeout");
                break;
            end
        end
        frames_exp[i] = frames_exp[i] + 16'd1;
        check("frames_sent", {16'd0, fs[i]}, {16'd0, frames_exp[i]});
        check("frame_drained", exp_q[i].size(), 0);
    endtask

    task automatic reset_checks();
        for (int i = 0; i < 2; i++) begin
            check("rst_tx_valid", {31'd0, tv[i]}, 32'd0);
            check("rst_tx_data", {24'd0, txd[i]}, 32'd0);
            check("rst_ready", {31'd0, pr[i]}, 32'd1);
            check("rst_frames", {16'd0, fs[i]}, 32'd0);
            check("rst_rx_last", {24'd0, rxl[i]}, 32'd0);
        end
    endtask

    task automatic rx_pulse(input logic [7:0] v);
        @(posedge clk);
        #1;
        rx_data  = v;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("rx_last_a", {24'd0, rxl[0]}, {24'd0, v});
        check("rx_last_b", {24'd0, rxl[1]}, {24'd0, v});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2 reset_checks();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed words from the framing examples
        offer(0, 32'h0000_1234); wait_done(0);
        offer(1, 32'hDEAD_BEEF); wait_done(1);
        offer(0, 32'h0000_0F3C); wait_done(0);

        // RX strobe while a frame is being sent
        offer(0, 32'h0000_A55A);
        rx_pulse(8'h5A);
        wait_done(0);

        // Stall mid-payload for 10 cycles while the payload input wanders
        offer(0, 32'h0000_C3E1);
        @(posedge clk);
        #2 mode = 2;
        repeat (10) begin
            @(posedge clk);
            #1 pay_a = 16'($urandom);
        end
        #1 mode = 0;
        wait_done(0);

        // Reset after two bytes of a frame, then a fresh frame
        offer(0, $urandom);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 reset_checks();
        frames_exp[0] = 16'h0;
        frames_exp[1] = 16'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        offer(0, 32'h0000_1234); wait_done(0);

        // Frame counter wrap
        @(negedge clk);
        force dut_a.frames_sent = 16'hFFFE;
        #1 release dut_a.frames_sent;
        frames_exp[0] = 16'hFFFE;
        offer(0, $urandom); wait_done(0);
        offer(0, $urandom); wait_done(0);

        // Random traffic on both instances with random ack and RX strobes
        mode = 1;
        fork
            for (int n = 0; n < 12; n++) begin
                offer(0, $urandom);
                wait_done(0);
            end
            for (int n = 0; n < 12; n++) begin
                offer(1, $urandom);
                wait_done(1);
            end
            for (int n = 0; n < 6; n++) begin
                repeat ($urandom_range(3, 20)) @(posedge clk);
                rx_pulse(8'($urandom));
            end
        join
        mode = 0;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
